usb_rx_ctrl: RTL and testbench

//  Receive control unit for the USB full-speed receiver. Sequences the decode /
//  bit-unstuff / shift-register datapath: counts unstuffed bit strobes into bytes,

---
 rtl/usb_rx_pkg.sv | 39 +++
 rtl/usb_rx_bit_counter.sv | 44 ++++
 rtl/usb_rx_ctrl.sv | 179 +++++++++++++++++
 tb/tb_usb_rx_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// -----------------------------------------------------------------------------
// usb_rx_pkg
// Shared types and constants for the USB full-speed receive control path.
//   rx_state_t : receive sequencer states
//   SYNC_BYTE  : SYNC pattern as it appears in the shift register (8'h80)
//   PID_*      : low-nibble PID codes
//   pid_ok()   : true when the PID check nibble is the complement of the code
// Optional feature macro used by the users of this package: USB_RX_PID_CHECK_EN
// -----------------------------------------------------------------------------
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_EOP_WAIT,
        ST_ERR,
        ST_ERR_IDLE
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    // Upper nibble of a PID byte carries the one's complement of the code.
    function automatic logic pid_ok(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_bit_counter.sv
// -----------------------------------------------------------------------------
// usb_rx_bit_counter
// 3-bit count of unstuffed bit strobes with a registered byte-complete pulse.
//   clk          in  system clock
//   n_rst        in  async active-low reset
//   i_clear      in  synchronous clear (packet start)
//   i_count_en   in  count one received bit
//   o_bit_count  out bits received in the current byte (0 = byte boundary)
//   o_byte_done  out 1-cycle pulse the cycle after the count wraps 7->0;
//                    the shift register output is complete while it is high
// -----------------------------------------------------------------------------
module usb_rx_bit_counter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_clear,
    input  logic       i_count_en,
    output logic [2:0] o_bit_count,
    output logic       o_byte_done
);

    logic [2:0] r_count;
    logic       r_byte_done;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count     <= 3'd0;
            r_byte_done <= 1'b0;
        end else if (i_clear) begin
            r_count     <= 3'd0;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= i_count_en && (r_count == 3'd7);
            if (i_count_en) begin
                r_count <= r_count + 3'd1;
            end
        end
    end

    assign o_bit_count = r_count;
    assign o_byte_done = r_byte_done;

endmodule

// File: rtl/usb_rx_ctrl.sv
// -----------------------------------------------------------------------------
// usb_rx_ctrl
// Receive sequencer for the USB full-speed receiver: frames unstuffed bits into
// bytes, checks SYNC, captures the PID, writes data bytes to the RX FIFO and
// flags packet errors.
//   clk, n_rst    clock, async active-low reset
//   d_edge        pulse: line transition seen
//   shift_enable  pulse: bit-sample instant
//   unstuff_hold  current sample is a stuffed bit (not counted)
//   eop           SE0 present
//   rx_byte       shift-register parallel output
//   rcving        reception in progress
//   w_enable      1-cycle FIFO write strobe for rx_byte
//   r_error       sticky packet error, cleared at next packet start
//   rx_done       1-cycle pulse on clean packet end
//   rx_pid        PID code of the last accepted PID byte
//   byte_count    data bytes written this packet (saturates at MAX_BYTES)
// Macro USB_RX_PID_CHECK_EN: when defined, a PID byte whose check nibble is not
// the complement of its code sends the packet to the error state.
// -----------------------------------------------------------------------------
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter  int MAX_BYTES = 64,
    localparam int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             shift_enable,
    input  logic             unstuff_hold,
    input  logic             eop,
    input  logic [7:0]       rx_byte,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic             rx_done,
    output logic [3:0]       rx_pid,
    output logic [CNT_W-1:0] byte_count
);

    rx_state_t        r_state;
    logic             r_rcving;
    logic             r_w_enable;
    logic             r_rx_done;
    logic             r_eop_seen;
    logic [3:0]       r_rx_pid;
    logic [CNT_W-1:0] r_byte_count;

    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic [2:0] w_bit_count;
    logic       w_byte_done;
    logic       w_at_max;
    logic       w_pid_bad;
    logic       w_write;
    logic       w_to_err;

    // Packet start: leaving an idle state on the first transition.
    assign w_cnt_clr = d_edge && (r_state == ST_IDLE || r_state == ST_ERR_IDLE);
    assign w_cnt_en  = r_rcving && shift_enable && !unstuff_hold;
    assign w_at_max  = (r_byte_count == CNT_W'(MAX_BYTES));
    assign w_write   = (r_state == ST_DATA) && w_byte_done && !w_at_max;

`ifdef USB_RX_PID_CHECK_EN
    assign w_pid_bad = !pid_ok(rx_byte);
`else
    assign w_pid_bad = 1'b0;
`endif

    usb_rx_bit_counter u_bit_counter (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_clear     (w_cnt_clr),
        .i_count_en  (w_cnt_en),
        .o_bit_count (w_bit_count),
        .o_byte_done (w_byte_done)
    );

    // NOTE: the default at the top of an always_comb keeps every path
    // assigned, so no latch is inferred.
    always_comb begin
        w_to_err = 1'b0;
        case (r_state)
            ST_SYNC: w_to_err = eop || (w_byte_done && rx_byte != SYNC_BYTE);
            ST_PID:  w_to_err = eop || (w_byte_done && w_pid_bad);
            // A byte arriving at the limit is dropped; an eop mid-byte means
            // the last byte was truncated.
            ST_DATA: w_to_err = (w_byte_done && w_at_max) ||
                                (eop && w_bit_count != 3'd0);
            default: w_to_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_rcving     <= 1'b0;
            r_w_enable   <= 1'b0;
            r_rx_done    <= 1'b0;
            r_error      <= 1'b0;
            r_eop_seen   <= 1'b0;
            r_rx_pid     <= 4'h0;
            r_byte_count <= '0;
        end else begin
            // NOTE: strobes default low every cycle, so each assertion
            // lasts exactly one clock.
            r_w_enable <= 1'b0;
            r_rx_done  <= 1'b0;

            // The write is taken before any eop decision in the same cycle.
            if (w_write) begin
                r_w_enable   <= 1'b1;
                r_byte_count <= r_byte_count + 1'b1;
            end

            if (w_to_err) begin
                r_state    <= ST_ERR;
                r_error    <= 1'b1;
                r_eop_seen <= eop;
            end else begin
                case (r_state)
                    ST_IDLE, ST_ERR_IDLE: begin
                        if (d_edge) begin
                            r_state      <= ST_SYNC;
                            r_rcving     <= 1'b1;
                            r_error      <= 1'b0;
                            r_byte_count <= '0;
                        end
                    end
                    ST_SYNC: begin
                        if (w_byte_done) begin
                            r_state <= ST_PID;
                        end
                    end
                    ST_PID: begin
                        if (w_byte_done) begin
                            r_rx_pid <= rx_byte[3:0];
                            r_state  <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (eop) begin
                            r_state <= ST_EOP_WAIT;
                        end
                    end
                    ST_EOP_WAIT: begin
                        if (d_edge) begin
                            r_state   <= ST_IDLE;
                            r_rcving  <= 1'b0;
                            r_rx_done <= 1'b1;
                        end
                    end
                    ST_ERR: begin
                        // Wait for the line to return to idle after the
                        // broken packet's SE0 before rearming.
                        if (eop) begin
                            r_eop_seen <= 1'b1;
                        end else if (d_edge && r_eop_seen) begin
                            r_state  <= ST_ERR_IDLE;
                            r_rcving <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_rcving <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rcving     = r_rcving;
    assign w_enable   = r_w_enable;
    assign rx_done    = r_rx_done;
    assign rx_pid     = r_rx_pid;
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_ctrl
// Directed + randomized packets for usb_rx_ctrl (MAX_BYTES = 4). Expected
// results come from a packet-level model: SYNC/PID/data bytes in, expected
// FIFO contents, byte count, error, done and PID out.
// Honours USB_RX_PID_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_usb_rx_ctrl;

    localparam int MAX_BYTES = 4;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);
`ifdef USB_RX_PID_CHECK_EN
    localparam bit PID_CHK = 1'b1;
`else
    localparam bit PID_CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             d_edge = 1'b0;
    logic             shift_enable = 1'b0;
    logic             unstuff_hold = 1'b0;
    logic             eop = 1'b0;
    logic [7:0]       rx_byte = 8'h00;
    logic             rcving;
    logic             w_enable;
    logic             r_error;
    logic             rx_done;
    logic [3:0]       rx_pid;
    logic [CNT_W-1:0] byte_count;

    usb_rx_ctrl #(.MAX_BYTES(MAX_BYTES)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_edge       (d_edge),
        .shift_enable (shift_enable),
        .unstuff_hold (unstuff_hold),
        .eop          (eop),
        .rx_byte      (rx_byte),
        .rcving       (rcving),
        .w_enable     (w_enable),
        .r_error      (r_error),
        .rx_done      (rx_done),
        .rx_pid       (rx_pid),
        .byte_count   (byte_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Output monitor: samples 1 ns after each rising edge.
    logic [7:0] wr_log[$];
    int         done_cnt  = 0;
    int         we_long   = 0;
    int         done_long = 0;
    bit         we_prev   = 1'b0;
    bit         done_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (w_enable === 1'b1) begin
            wr_log.push_back(rx_byte);
            if (we_prev) we_long++;
        end
        if (rx_done === 1'b1) begin
            if (done_prev) done_long++;
            else           done_cnt++;
        end
        we_prev   = (w_enable === 1'b1);
        done_prev = (rx_done === 1'b1);
    end

    // Reference model state
    logic [3:0] exp_pid = 4'h0;
    logic [7:0] tx_data[$];
    logic [7:0] exp_q[$];
    bit         exp_err;
    bit         exp_done;

    logic [7:0] pid_tab [9] = '{8'hE1, 8'h69, 8'hA5, 8'h2D, 8'hC3,
                                8'h4B, 8'hD2, 8'h5A, 8'h1E};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Packet-level prediction from the byte list.
    task automatic predict(input logic [7:0] sync_b, input logic [7:0] pid_b,
                           input int n_data, input int partial);
        int n_wr;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_done = 1'b0;
        if (sync_b != 8'h80) begin
            exp_err = 1'b1;
        end else if (PID_CHK && ((pid_b[7:4] ^ pid_b[3:0]) != 4'hF)) begin
            exp_err = 1'b1;
        end else begin
            exp_pid = pid_b[3:0];
            n_wr = (n_data > MAX_BYTES) ? MAX_BYTES : n_data;
            for (int i = 0; i < n_wr; i++) exp_q.push_back(tx_data[i]);
            if (n_data > MAX_BYTES || partial != 0) exp_err = 1'b1;
            else                                    exp_done = 1'b1;
        end
    endtask

    // One bit strobe; a stuffed strobe does not shift the register.
    task automatic strobe(input bit hold, input bit b);
        @(negedge clk);
        shift_enable = 1'b1;
        unstuff_hold = hold;
        d_edge       = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        shift_enable = 1'b0;
        unstuff_hold = 1'b0;
        d_edge       = 1'b0;
        if (!hold) rx_byte = {b, rx_byte[7:1]};
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input int stuff_at);
        for (int i = 0; i < n; i++) begin
            if (i == stuff_at) strobe(1'b1, 1'b0);
            strobe(1'b0, b[i]);
        end
    endtask

    task automatic start_pkt();
        @(negedge clk);
        d_edge = 1'b1;
        @(negedge clk);
        d_edge = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic end_pkt();
        @(negedge clk);
        eop    = 1'b1;
        d_edge = 1'b1;
        @(negedge clk);
        d_edge = 1'b0;
        repeat (4) @(negedge clk);
        check("rcving_in_eop", rcving, 1);
        eop    = 1'b0;
        d_edge = 1'b1;
        @(negedge clk);
        d_edge = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_pkt(input string name, input logic [7:0] sync_b,
                           input logic [7:0] pid_b, input int n_data,
                           input int stuff_idx, input int partial);
        int base = wr_log.size();
        int dc0  = done_cnt;
        int wl0  = we_long;
        int dl0  = done_long;
        tx_data.delete();
        for (int i = 0; i < n_data; i++) tx_data.push_back(8'($urandom));
        predict(sync_b, pid_b, n_data, partial);
        start_pkt();
        send_bits(sync_b, 8, -1);
        check({name, "_rcving"}, rcving, 1);
        send_bits(pid_b, 8, -1);
        for (int i = 0; i < n_data; i++)
            send_bits(tx_data[i], 8, (i == stuff_idx) ? int'($urandom_range(1, 7)) : -1);
        if (partial != 0) send_bits(8'($urandom), partial, -1);
        end_pkt();
        check({name, "_writes"}, wr_log.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < wr_log.size(); i++)
            check({name, "_data"}, wr_log[base + i], exp_q[i]);
        check({name, "_byte_count"}, byte_count, exp_q.size());
        check({name, "_r_error"}, r_error, exp_err);
        check({name, "_rx_done"}, done_cnt - dc0, exp_done);
        check({name, "_pulse_width"}, (we_long - wl0) + (done_long - dl0), 0);
        check({name, "_rx_pid"}, rx_pid, exp_pid);
        check({name, "_rcving_idle"}, rcving, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rcving"}, rcving, 0);
        check({name, "_w_enable"}, w_enable, 0);
        check({name, "_r_error"}, r_error, 0);
        check({name, "_rx_done"}, rx_done, 0);
        check({name, "_rx_pid"}, rx_pid, 0);
        check({name, "_byte_count"}, byte_count, 0);
    endtask

    initial begin
        int base;
        logic [7:0] sync_b;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("after_reset");

        // Token packet, no data
        run_pkt("token", 8'h80, 8'hE1, 0, -1, 0);
        check("token_pid_is_1", rx_pid, 4'h1);

        // Data packet, bit stuffing inside the second data byte
        run_pkt("data3", 8'h80, 8'hC3, 3, 1, 0);

        // Bad SYNC, then a good packet clears the error
        run_pkt("bad_sync", 8'h81, 8'hD2, 2, -1, 0);
        run_pkt("after_bad", 8'h80, 8'h4B, 2, 0, 0);

        // eop four bits into a data byte
        run_pkt("partial", 8'h80, 8'hC3, 1, -1, 4);

        // One byte beyond the limit
        run_pkt("overflow", 8'h80, 8'h4B, 5, 2, 0);

        // Reset in the middle of DATA
        base = wr_log.size();
        start_pkt();
        send_bits(8'h80, 8, -1);
        send_bits(8'hD2, 8, -1);
        send_bits(8'($urandom), 8, -1);
        send_bits(8'($urandom), 8, -1);
        send_bits(8'($urandom), 3, -1);
        check("mid_rst_prewrites", wr_log.size() - base, 2);
        @(negedge clk);
        n_rst = 1'b0;
        exp_pid = 4'h0;
        @(negedge clk);
        check_all_zero("mid_rst");
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        run_pkt("post_rst", 8'h80, 8'hC3, 2, -1, 0);

        // PID with a wrong check nibble
        run_pkt("pid_e2", 8'h80, 8'hE2, 0, -1, 0);
        check("pid_e2_err", r_error, PID_CHK ? 1 : 0);

        // Randomized packets
        for (int k = 0; k < 10; k++) begin
            sync_b = ($urandom_range(0, 5) == 0) ? (8'h80 ^ (8'h01 << $urandom_range(0, 7)))
                                                 : 8'h80;
            run_pkt("rand", sync_b, pid_tab[$urandom_range(0, 8)],
                    int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 5)) - 1,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
